// File: rtl/pattern_gen_if.sv
// Control/observation bundle for pattern_gen: step controls and load port in,
// registered pattern and tick out.
interface pattern_gen_if #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 16
);
   logic             enable;
   logic [1:0]       mode;
   logic [DIV_W-1:0] div;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] pattern;
   logic             tick;

   modport master (
      output enable, mode, div, load, load_data,
      input  pattern, tick
   );

   modport slave (
      input  enable, mode, div, load, load_data,
      output pattern, tick
   );
endinterface

// File: rtl/pattern_gen.sv
// Programmable pattern generator: a prescaler sets the step rate and each step
// holds, rotates, counts or bounces a single bit across the pattern register.
module pattern_gen #(
   parameter int               WIDTH = 8,
   parameter int               DIV_W = 16,
   parameter logic [WIDTH-1:0] INIT  = WIDTH'(8'h50)
) (
   input logic          clk,
   input logic          rst_n,
   pattern_gen_if.slave bus
);

   typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] pattern_q, pattern_d;
   dir_e             dir_q, dir_d;
   logic             tick_q, tick_d;
   logic             step;
   logic             onehot;

   assign onehot = (pattern_q != '0) &&
                   ((pattern_q & (pattern_q - WIDTH'(1))) == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         pattern_q <= INIT;
         dir_q     <= UP;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pattern_q <= pattern_d;
         dir_q     <= dir_d;
         tick_q    <= tick_d;
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      pattern_d = pattern_q;
      dir_d     = dir_q;
      tick_d    = 1'b0;
      step      = 1'b0;

      if (bus.load) begin
         pattern_d = bus.load_data;
         cnt_d     = '0;
         dir_d     = UP;
      end else if (bus.enable) begin
         // A lowered div lets cnt run through all-ones and wrap before matching.
         if (cnt_q == bus.div) begin
            cnt_d  = '0;
            step   = 1'b1;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end

      if (step) begin
         case (bus.mode)
            2'b01: pattern_d = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
            2'b10: pattern_d = pattern_q + WIDTH'(1);
            2'b11: begin
               if (!onehot) begin
                  pattern_d = WIDTH'(1);
                  dir_d     = UP;
               end else begin
                  case (dir_q)
                     UP: begin
                        if (pattern_q[WIDTH-1]) begin
                           dir_d     = DOWN;
                           pattern_d = {1'b0, pattern_q[WIDTH-1:1]};
                        end else begin
                           pattern_d = {pattern_q[WIDTH-2:0], 1'b0};
                        end
                     end
                     DOWN: begin
                        if (pattern_q[0]) begin
                           dir_d     = UP;
                           pattern_d = {pattern_q[WIDTH-2:0], 1'b0};
                        end else begin
                           pattern_d = {1'b0, pattern_q[WIDTH-1:1]};
                        end
                     end
                     default: dir_d = UP;
                  endcase
               end
            end
            default: pattern_d = pattern_q;
         endcase
      end
   end

   assign bus.pattern = pattern_q;
   assign bus.tick    = tick_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: a behavioural model predicts pattern/tick
// per cycle, a monitor compares each registered output against the queue.
module tb_pattern_gen;
   localparam int W    = 8;
   localparam int DW   = 4;
   localparam int MASK = (1 << W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pattern_gen_if #(.WIDTH(W), .DIV_W(DW)) bus ();

   pattern_gen #(.WIDTH(W), .DIV_W(DW), .INIT(8'h50)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   typedef struct {
      logic [W-1:0] pat;
      logic         tick;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   int m_pat, m_cnt;
   bit m_up, m_tick;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int bounce_pos(input int p);
      int pos = -1;
      for (int i = 0; i < W; i++) if (p == (1 << i)) pos = i;
      return pos;
   endfunction

   task automatic model_reset();
      m_pat = 8'h50; m_cnt = 0; m_up = 1; m_tick = 0;
   endtask

   task automatic model_step(input bit en, input int md, input int dv, input bit ld, input int ldd);
      int pos;
      m_tick = 0;
      if (ld) begin
         m_pat = ldd & MASK; m_cnt = 0; m_up = 1;
      end else if (en) begin
         if (m_cnt == dv) begin
            m_cnt  = 0;
            m_tick = 1;
            case (md)
               1: m_pat = ((m_pat << 1) | (m_pat >> (W - 1))) & MASK;
               2: m_pat = (m_pat + 1) & MASK;
               3: begin
                  pos = bounce_pos(m_pat);
                  if (pos < 0) begin
                     pos = 0; m_up = 1;
                  end else if (m_up) begin
                     if (pos == W - 1) begin m_up = 0; pos = pos - 1; end
                     else pos = pos + 1;
                  end else begin
                     if (pos == 0) begin m_up = 1; pos = 1; end
                     else pos = pos - 1;
                  end
                  m_pat = 1 << pos;
               end
               default: ;
            endcase
         end else begin
            m_cnt = (m_cnt + 1) % (1 << DW);
         end
      end
   endtask

   // Called at a falling edge: drive, predict the next posedge, wait one cycle.
   task automatic cyc(input bit en, input int md, input int dv, input bit ld, input int ldd);
      exp_t e;
      bus.enable    = en;
      bus.mode      = 2'(md);
      bus.div       = DW'(dv);
      bus.load      = ld;
      bus.load_data = W'(ldd);
      model_step(en, md, dv, ld, ldd);
      e.pat  = W'(m_pat);
      e.tick = m_tick;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic reset_mid();
      exp_t e;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_pattern", bus.pattern, 8'h50);
      chk("async_rst_tick", bus.tick, 0);
      model_reset();
      e.pat  = 8'h50;
      e.tick = 1'b0;
      q.push_back(e);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pattern", bus.pattern, e.pat);
            chk("tick", bus.tick, e.tick);
         end
      end
   end

   initial begin : stim
      int md, dv;
      bit en, ld;
      bus.enable = 0; bus.mode = 0; bus.div = 0; bus.load = 0; bus.load_data = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_pattern", bus.pattern, 8'h50);
      chk("reset_tick", bus.tick, 0);
      model_reset();
      rst_n = 1'b1;

      // hold mode, div=3: pattern stays, tick every 4 cycles
      repeat (12) cyc(1, 0, 3, 0, 0);
      chk("hold_pattern", bus.pattern, 8'h50);

      // rotate-left from 0x81 at full rate
      cyc(1, 1, 0, 1, 8'h81);
      repeat (3) cyc(1, 1, 0, 0, 0);
      chk("rotate_third", bus.pattern, 8'h0C);

      // up-count wrap at div=1
      cyc(1, 2, 1, 1, 8'hFE);
      repeat (4) cyc(1, 2, 1, 0, 0);
      chk("count_wrap", bus.pattern, 8'h00);

      // bounce across the MSB
      cyc(1, 3, 0, 1, 8'h40);
      repeat (3) cyc(1, 3, 0, 0, 0);
      chk("bounce_third", bus.pattern, 8'h20);

      // bounce from a non one-hot reset value
      reset_mid();
      cyc(1, 3, 0, 0, 0);
      chk("bounce_from_init", bus.pattern, 8'h01);

      // load coincident with a step
      cyc(1, 2, 2, 1, 8'h10);
      repeat (2) cyc(1, 2, 2, 0, 0);
      cyc(1, 2, 2, 1, 8'h33);
      chk("load_vs_step_pat", bus.pattern, 8'h33);
      chk("load_vs_step_tick", bus.tick, 0);
      repeat (3) cyc(1, 2, 2, 0, 0);
      chk("after_load_step", bus.pattern, 8'h34);

      // enable low freezes everything
      repeat (5) cyc(0, 1, 0, 0, 0);

      // div lowered below cnt forces a wrap of the prescaler
      cyc(1, 2, 3, 1, 8'h00);
      repeat (2) cyc(1, 2, 3, 0, 0);
      repeat (16) cyc(1, 2, 1, 0, 0);

      // reset mid-count while counting
      repeat (3) cyc(1, 2, 1, 0, 0);
      reset_mid();
      repeat (4) cyc(1, 2, 1, 0, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) reset_mid();
         en = ($urandom_range(0, 9) != 0);
         ld = ($urandom_range(0, 19) == 0);
         md = int'($urandom_range(0, 3));
         dv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
         cyc(en, md, dv, ld, int'($urandom_range(0, 255)));
      end

      @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
